fb_scanout: RTL and testbench

Parametrised paletted framebuffer scan-out engine sitting between the framebuffer BRAMs and the `hdmi` transmitter in the `clk_pixel` domain. It turns the transmitter's `cx`/`cy` raster position into framebuffer and palette read addresses and returns 24-bit RGB aligned to that position. It generalises the fixed 8-bpp 1:1 framebuffer read path with selectable bits per pixel, power-of-two integer scaling, automatic centring with a border colour, and double-buffered page flipping at vblank.

---
 rtl/fb_pkg.sv | 17 +
 rtl/fb_scanout_if.sv | 15 +
 rtl/fb_coord_lookahead.sv | 25 ++
 rtl/fb_scanout.sv | 137 +++++++++++++
 tb/tb_fb_scanout.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared constants, types and elaboration helpers for the paletted scan-out engine.
package fb_pkg;

  localparam int LAT = 4;

  typedef logic [23:0] rgb24_t;
  typedef int unsigned bpp_t;

  function automatic bit bpp_legal(input bpp_t bpp);
    return (bpp == 1) || (bpp == 2) || (bpp == 4) || (bpp == 8);
  endfunction

  function automatic int page_bytes(input int fb_width, input int fb_height, input int bpp);
    return (fb_width * fb_height * bpp) / 8;
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer and palette RAM read ports; both RAMs return data one cycle after the address register.
interface fb_scanout_if #(
  parameter int ADDR_W = 17
);
  import fb_pkg::*;

  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;
  logic [7:0]        pal_addr;
  rgb24_t            pal_data;

  modport master (output fb_addr, output pal_addr, input fb_data, input pal_data);
  modport slave  (input fb_addr, input pal_addr, output fb_data, output pal_data);

endinterface

// File: rtl/fb_coord_lookahead.sv
// Raster position advanced by LAT pixels, wrapping X at frame_width and Y at frame_height.
module fb_coord_lookahead
  import fb_pkg::*;
(
  input  logic [11:0] cx,
  input  logic [11:0] cy,
  input  logic [11:0] frame_width,
  input  logic [11:0] frame_height,
  output logic [11:0] xl,
  output logic [11:0] yl
);

  logic wrap;

  // Comparing against frame_width - LAT avoids any 12-bit overflow of cx + LAT.
  always_comb begin
    wrap = cx >= (frame_width - 12'(LAT));
    xl   = wrap ? (cx - (frame_width - 12'(LAT))) : (cx + 12'(LAT));
    yl   = cy;
    if (wrap) begin
      yl = (cy >= (frame_height - 12'd1)) ? '0 : (cy + 12'd1);
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// Paletted framebuffer scan-out: lookahead, centring/scaling, sub-byte unpack, palette lookup, page flip.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240,
  parameter int BPP        = 8,
  parameter int SCALE_LOG2 = 0,
  parameter int PAGES      = 2,
  parameter int FB_ADDR_W  = $clog2(PAGES * FB_WIDTH * FB_HEIGHT * BPP / 8)
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic [11:0]         cx,
  input  logic [11:0]         cy,
  input  logic [11:0]         frame_width,
  input  logic [11:0]         frame_height,
  input  logic [11:0]         screen_width,
  input  logic [11:0]         screen_height,
  input  rgb24_t              border_rgb,
  input  logic                flip_req,
  output logic                flip_ack,
  output logic                back_page,
  fb_scanout_if.master        mem,
  output rgb24_t              rgb,
  output logic                hblank,
  output logic                vblank
);

  localparam int          PAGE_BYTES = page_bytes(FB_WIDTH, FB_HEIGHT, BPP);
  localparam int          PPB        = 8 / BPP;
  localparam int          PIX_MASK   = (1 << BPP) - 1;
  localparam logic [12:0] SW13       = 13'(FB_WIDTH << SCALE_LOG2);
  localparam logic [12:0] SH13       = 13'(FB_HEIGHT << SCALE_LOG2);

  if (!bpp_legal(BPP)) begin : g_bad_bpp
    $error("fb_scanout: BPP must be 1, 2, 4 or 8");
  end
  if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : g_bad_scale
    $error("fb_scanout: SCALE_LOG2 must be 0..2");
  end
  if (PAGES != 1 && PAGES != 2) begin : g_bad_pages
    $error("fb_scanout: PAGES must be 1 or 2");
  end

  logic        page, pending, vblank_start;
  logic [11:0] xl, yl, xl_p0, yl_p0, ox, oy, dx, dy;
  logic [12:0] x_end, y_end;
  logic [31:0] lin;
  logic        inside_s1, inside_p1, inside_p2;
  logic [2:0]  sel_s1, sel_p1;
  logic [FB_ADDR_W-1:0] addr_s1;
  logic [7:0]  pix_idx;
  logic        vld_p0, vld_p1, vld_p2;

  fb_coord_lookahead u_lookahead (
    .cx           (cx),
    .cy           (cy),
    .frame_width  (frame_width),
    .frame_height (frame_height),
    .xl           (xl),
    .yl           (yl)
  );

  // Stage 1: centring offsets, image test and byte address of the lookahead pixel.
  always_comb begin
    ox        = ({1'b0, screen_width} > SW13) ? 12'(({1'b0, screen_width} - SW13) >> 1) : '0;
    oy        = ({1'b0, screen_height} > SH13) ? 12'(({1'b0, screen_height} - SH13) >> 1) : '0;
    x_end     = {1'b0, ox} + SW13;
    y_end     = {1'b0, oy} + SH13;
    inside_s1 = (xl_p0 >= ox) && ({1'b0, xl_p0} < x_end) && (yl_p0 >= oy) && ({1'b0, yl_p0} < y_end)
              && (xl_p0 < screen_width) && (yl_p0 < screen_height);
    dx        = xl_p0 - ox;
    dy        = yl_p0 - oy;
    lin       = 32'(dy >> SCALE_LOG2) * 32'(FB_WIDTH) + 32'(dx >> SCALE_LOG2);
    addr_s1   = FB_ADDR_W'((lin * 32'(BPP)) >> 3) + (page ? FB_ADDR_W'(PAGE_BYTES) : '0);
    sel_s1    = 3'(lin % 32'(PPB));
  end

  // Stage 2: pixel 0 sits in the byte's LSBs.
  assign pix_idx = 8'(mem.fb_data >> (32'(BPP) * 32'(sel_p1))) & 8'(PIX_MASK);

  always_ff @(posedge clk_pixel) begin
    xl_p0     <= xl;
    yl_p0     <= yl;
    sel_p1    <= sel_s1;
    inside_p1 <= inside_s1;
    inside_p2 <= inside_p1;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      mem.fb_addr  <= '0;
      mem.pal_addr <= '0;
      rgb          <= '0;
    end else begin
      vld_p0       <= 1'b1;
      vld_p1       <= vld_p0;
      vld_p2       <= vld_p1;
      mem.fb_addr  <= addr_s1;
      mem.pal_addr <= pix_idx;
      // Stage 3: palette colour inside the image, border everywhere else.
      rgb          <= (vld_p2 && inside_p2) ? mem.pal_data : border_rgb;
    end
  end

  assign vblank_start = (cx == 12'd0) && (cy == screen_height);

  // A request landing on the vblank-start cycle flips immediately; repeats in a frame collapse.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      page      <= 1'b0;
      pending   <= 1'b0;
      flip_ack  <= 1'b0;
      back_page <= 1'(PAGES == 2);
      hblank    <= 1'b0;
      vblank    <= 1'b0;
    end else begin
      hblank    <= cx >= screen_width;
      vblank    <= cy >= screen_height;
      flip_ack  <= vblank_start;
      back_page <= (PAGES == 2) ? ~page : 1'b0;
      if (PAGES == 2) begin
        if (vblank_start && (pending || flip_req)) begin
          page    <= ~page;
          pending <= 1'b0;
        end else if (flip_req) begin
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Randomised scoreboard bench for fb_scanout on a small raster with 4-bpp, 2x scaling and two pages.
module tb_fb_scanout;
  import fb_pkg::*;

  localparam int FBW = 16, FBH = 8, BPP = 4, SC = 1, PG = 2;
  localparam int AW  = $clog2(PG * FBW * FBH * BPP / 8);
  localparam int PB  = FBW * FBH * BPP / 8;
  localparam int FRW = 64, FRH = 40, SCW = 48, SCH = 30;
  localparam int FRAME = FRW * FRH;
  localparam int NFRAMES = 9;

  typedef struct { int due; bit rst; rgb24_t col; } rgb_e_t;
  typedef struct { int due; int addr; } addr_e_t;
  typedef struct { int due; bit ack; bit hb; bit vb; } ev_e_t;
  typedef struct { int due; bit val; } bp_e_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] cx, cy;
  logic [11:0] frame_width = 12'(FRW), frame_height = 12'(FRH);
  logic [11:0] screen_width = 12'(SCW), screen_height = 12'(SCH);
  rgb24_t      border_rgb;
  logic        flip_req, flip_ack, back_page, hblank, vblank;
  rgb24_t      rgb;

  logic [7:0]  fb_mem [PG*PB];
  rgb24_t      pal_mem [256];

  int checks = 0, errors = 0, edges = 0;
  int m_page = 0;
  bit m_pend = 0;
  rgb_e_t  rgb_q[$];
  addr_e_t addr_q[$];
  ev_e_t   ev_q[$];
  bp_e_t   bp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  fb_scanout_if #(.ADDR_W(AW)) mem ();
  assign mem.fb_data  = fb_mem[mem.fb_addr];
  assign mem.pal_data = pal_mem[mem.pal_addr];

  fb_scanout #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .BPP(BPP), .SCALE_LOG2(SC), .PAGES(PG)) dut (
    .clk_pixel     (clk),
    .reset         (reset),
    .cx            (cx),
    .cy            (cy),
    .frame_width   (frame_width),
    .frame_height  (frame_height),
    .screen_width  (screen_width),
    .screen_height (screen_height),
    .border_rgb    (border_rgb),
    .flip_req      (flip_req),
    .flip_ack      (flip_ack),
    .back_page     (back_page),
    .mem           (mem),
    .rgb           (rgb),
    .hblank        (hblank),
    .vblank        (vblank)
  );

  function automatic void ref_pixel(input int x, input int y, input int page,
                                    output bit in_img, output int addr, output rgb24_t col);
    int sw, sh, ox, oy, n, ppb, pix;
    sw = FBW * (1 << SC);
    sh = FBH * (1 << SC);
    ox = (SCW > sw) ? (SCW - sw) / 2 : 0;
    oy = (SCH > sh) ? (SCH - sh) / 2 : 0;
    in_img = x >= ox && x < ox + sw && y >= oy && y < oy + sh && x < SCW && y < SCH;
    addr = 0;
    col  = border_rgb;
    if (in_img) begin
      n    = ((y - oy) / (1 << SC)) * FBW + (x - ox) / (1 << SC);
      ppb  = 8 / BPP;
      addr = page * PB + n / ppb;
      pix  = (int'(fb_mem[addr]) >> ((n % ppb) * BPP)) % (1 << BPP);
      col  = pal_mem[pix];
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, edges, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (rgb_q.size() > 0 && rgb_q[0].due < edges) begin
      chk("rgb_entry_missed", 32'(rgb_q[0].due), 32'(edges));
      void'(rgb_q.pop_front());
    end
    if (rgb_q.size() > 0 && rgb_q[0].due == edges) begin
      if (rgb_q[0].rst) begin
        chk("reset_rgb", 32'(rgb), 32'd0);
        chk("reset_fb_addr", 32'(mem.fb_addr), 32'd0);
        chk("reset_pal_addr", 32'(mem.pal_addr), 32'd0);
      end else begin
        chk("rgb", 32'(rgb), 32'(rgb_q[0].col));
      end
      void'(rgb_q.pop_front());
    end
    if (addr_q.size() > 0 && addr_q[0].due == edges) begin
      chk("fb_addr", 32'(mem.fb_addr), 32'(addr_q[0].addr));
      void'(addr_q.pop_front());
    end
    if (ev_q.size() > 0 && ev_q[0].due == edges) begin
      chk("flip_ack", 32'(flip_ack), 32'(ev_q[0].ack));
      chk("hblank", 32'(hblank), 32'(ev_q[0].hb));
      chk("vblank", 32'(vblank), 32'(ev_q[0].vb));
      void'(ev_q.pop_front());
    end
    if (bp_q.size() > 0 && bp_q[0].due == edges) begin
      chk("back_page", 32'(back_page), 32'(bp_q[0].val));
      void'(bp_q.pop_front());
    end
  end

  initial begin
    int pos, f, la, r;
    bit in_img, vs;
    int addr;
    rgb24_t col;
    for (int i = 0; i < PG * PB; i++) fb_mem[i] = 8'($urandom);
    fb_mem[0] = 8'hA5;
    for (int i = 0; i < 256; i++) pal_mem[i] = 24'($urandom);
    border_rgb = 24'($urandom);
    reset = 1'b1;
    cx = '0;
    cy = '0;
    flip_req = 1'b0;

    for (int k = 0; k < NFRAMES * FRAME; k++) begin
      @(posedge clk);
      #1;
      pos = k % FRAME;
      f   = k / FRAME;
      cx  = 12'(pos % FRW);
      cy  = 12'(pos / FRW);
      reset = (k < 3) || (f == 6 && pos >= 12 * FRW + 20 && pos < 12 * FRW + 26)
           || (f == 7 && pos >= 18 * FRW + 58 && pos < 18 * FRW + 60);
      if (f == 6 && pos == 12 * FRW + 22) border_rgb = 24'($urandom);
      flip_req = ($urandom_range(0, 1499) == 0)
              || (f == 1 && cx == 0 && cy == 12'(SCH))
              || (f == 2 && cx == 3 && (cy == 5 || cy == 20))
              || (f == 3 && cx == 0 && cy == 10)
              || (f == 6 && cx == 7 && cy == 5);

      r = edges + 1;
      if (reset) begin
        m_page = 0;
        m_pend = 0;
        while (rgb_q.size() > 0 && rgb_q[$].due >= r) void'(rgb_q.pop_back());
        while (addr_q.size() > 0 && addr_q[$].due >= r) void'(addr_q.pop_back());
        foreach (bp_q[i]) if (bp_q[i].due >= r) bp_q[i].val = 1'b1;
        rgb_q.push_back('{due: r, rst: 1'b1, col: '0});
        ev_q.push_back('{due: r, ack: 1'b0, hb: 1'b0, vb: 1'b0});
      end else begin
        vs = (cx == 0) && (cy == 12'(SCH));
        ev_q.push_back('{due: r, ack: vs, hb: (cx >= 12'(SCW)), vb: (cy >= 12'(SCH))});
        if (vs) begin
          if (m_pend || flip_req) begin
            m_page = 1 - m_page;
            m_pend = 0;
          end
        end else if (flip_req) begin
          m_pend = 1;
        end
        la = (pos + LAT) % FRAME;
        ref_pixel(la % FRW, la / FRW, m_page, in_img, addr, col);
        rgb_q.push_back('{due: edges + 4, rst: 1'b0, col: col});
        if (in_img) addr_q.push_back('{due: edges + 2, addr: addr});
      end
      bp_q.push_back('{due: edges + 2, val: (m_page == 0)});
    end

    flip_req = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("queues_drained", 32'(rgb_q.size() + addr_q.size() + ev_q.size() + bp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
